spi_tx_arbiter: RTL
===================

# spi_tx_arbiter

- Sequences the SPI slave's MISO parallel-to-serial shifter and shares it between N transmit requesters using round-robin arbitration.
- For each transfer it:
  - accepts one requester's W-bit word;
  - issues a single load pulse to the shifter;
  - issues exactly W shift enables, paced by the SPI front end's bit tick;
  - reports completion.
- Sits between the register-file/response sources and the shifter, inside the SPI slave top.

## Interface
Parameters
- W, 8, data word width (bits per transfer)
- N, 4, number of requesters (N >= 2)

Ports
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- req  input  N  per-requester "word ready"; held until granted
- req_data  input  N*W  packed words, requester i at bits [i*W +: W]
- ss_n  input  1  SPI chip select, synchronized, active-low
- bit_tick  input  1  one-cycle pulse per SPI bit period (MISO update edge)
- grant  output  N  one-hot, one-cycle pulse: requester's word accepted
- load  output  1  one-cycle pulse: shifter loads load_data
- load_data  output  W  word for the shifter, valid while load=1
- shift_en  output  1  one-cycle pulse: shifter advances one bit
- busy  output  1  high from load cycle through last shift
- done  output  1  one-cycle pulse after W-th shift
- aborted  output  1  one-cycle pulse when ss_n rises mid-transfer
- underrun  output  1  sticky underrun flag (see Configuration)

## Operation
- FSM states: IDLE, SHIFT.
- Reset: state=IDLE, round-robin pointer=0, bit count=0; all outputs 0.
- IDLE, when ss_n=0 and req!=0:
  - Select the first asserted req at or above the pointer, wrapping modulo N.
  - Next cycle: grant[i]=1, load=1, load_data=req_data slice i, busy=1; state=SHIFT, count=0.
  - Pointer becomes i+1 mod N.
- IDLE with ss_n=1: no grant, regardless of req.
- SHIFT:
  - shift_en = bit_tick, except in the load cycle, where bit_tick is ignored (no shift_en, not counted).
  - Each counted tick increments count.
  - On the tick with count=W-1: state=IDLE and done=1 next cycle; busy drops with done.
- ss_n=1 during SHIFT (including the load cycle):
  - state=IDLE and count=0 next cycle, with aborted=1 and done=0.
  - The word is lost; the requester is not re-granted for it.
- Simultaneous ss_n rise and final tick: abort wins; shift_en is still emitted for that tick.
- Pointer is updated only on grant; aborts do not rewind it.

## Timing
- Arbitration latency: req/ss_n sampled at cycle t; grant, load and load_data at t+1.
- Final tick at cycle T gives done at T+1.
  - Earliest next load is T+2 (arbitration happens in the done cycle).
- Transfer occupancy: 1 load cycle + W ticks + 1 done cycle.
- shift_en is combinational from bit_tick and state (same cycle).
  - All other outputs are registered.
- A requester must hold req and req_data stable until its grant pulse.
  - Deasserting req before grant is legal; that request is simply not served.

## Configuration
- Macro: SPI_TX_ARB_UNDERRUN_EN.
- Defined:
  - underrun sets when bit_tick=1 in IDLE with ss_n=0 and req=0 (master clocking with no word queued).
  - underrun stays set until ss_n=1 or reset.
- Undefined: underrun is tied to 0 and its logic is absent; the port stays for interface stability.

## Structure
- Shared package spi_pkg holds:
  - the state enum typedef (IDLE, SHIFT);
  - the default word width constant (SPI_W = 8).
- Sub-module rr_arbiter (parameter N):
  - inputs req and pointer; output one-hot grant;
  - purely combinational;
  - instantiated once.
- Counter width is $clog2(W)+1.

## Test plan
- Single request:
  - Stimulus: ss_n=0, req=4'b0001, data0=8'hA5.
  - Expected: grant=0001 and load with load_data=A5 one cycle later; exactly 8 shift_en over 8 ticks; done one cycle after 8th tick.
- Round-robin:
  - Stimulus: req=4'b1111 held, repeated transfers.
  - Expected: grants in order 0,1,2,3,0; each grant pulse is one cycle, one-hot.
- Load-cycle tick:
  - Stimulus: bit_tick asserted in the load cycle.
  - Expected: no shift_en; still exactly 8 counted shifts before done.
- Abort:
  - Stimulus: ss_n rises after 3 ticks.
  - Expected: aborted pulse, no done, busy=0, pointer already advanced.
  - Follow-up: ss_n low again with req=4'b0010 → grant=0010.
- Reset mid-transfer:
  - Stimulus: rst_n=0 during SHIFT.
  - Expected: next cycle all outputs 0, IDLE; next grant goes to req0 if asserted.
- Underrun (macro defined):
  - Stimulus: ss_n=0, req=0, one tick.
  - Expected: underrun=1 and held; cleared when ss_n=1.
  - Macro undefined: underrun stays 0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave transmit path: FSM state encoding
// and the default word width.
package spi_pkg;

  localparam int SPI_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request at or
// above the pointer, wrapping modulo N. Grant is one-hot, or zero when no
// request is pending.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] idx_s;
  logic          found_s;

  // Scan requesters starting at the pointer and keep the first hit.
  always_comb begin
    grant   = '0;
    found_s = 1'b0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = PW'((int'(ptr) + k) % N);
      if (!found_s && req[idx_s]) begin
        grant[idx_s] = 1'b1;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: shares the MISO parallel-to-serial shifter between N
// transmit requesters. Each transfer is one load pulse followed by exactly
// W shift enables paced by bit_tick, then a done pulse. A rise of ss_n
// mid-transfer drops the word and pulses aborted.
// Optional feature macro: SPI_TX_ARB_UNDERRUN_EN (sticky underrun flag).
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int W = SPI_W,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] req_data,
  input  logic           ss_n,
  input  logic           bit_tick,
  output logic [N-1:0]   grant,
  output logic           load,
  output logic [W-1:0]   load_data,
  output logic           shift_en,
  output logic           busy,
  output logic           done,
  output logic           aborted,
  output logic           underrun
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(W) + 1;

  spi_state_e    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          load_q, load_d;
  logic [W-1:0]  load_data_q, load_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  logic [N-1:0]  arb_grant_s;
  logic [PW-1:0] next_ptr_s;
  logic [W-1:0]  sel_data_s;
  logic          start_s;
  logic          tick_s;
  logic          last_s;
  logic          abort_s;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant_s)
  );

  // A transfer starts only from IDLE with the chip selected and work queued.
  assign start_s = (state_q == IDLE) && !ss_n && (req != '0);
  // The load cycle is the first SHIFT cycle; its tick is not a shift.
  assign tick_s  = (state_q == SHIFT) && bit_tick && !load_q;
  assign last_s  = tick_s && (count_q == CW'(W - 1));
  assign abort_s = (state_q == SHIFT) && ss_n;

  // Shifting follows the bit tick directly so the shifter moves on the same edge.
  assign shift_en = tick_s;

  // Decode the winning requester into its word and the pointer that follows it.
  always_comb begin
    sel_data_s = '0;
    next_ptr_s = ptr_q;
    for (int i = 0; i < N; i++) begin
      if (arb_grant_s[i]) begin
        sel_data_s = req_data[i*W +: W];
        next_ptr_s = (i == N - 1) ? '0 : PW'(i + 1);
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      ptr_q       <= '0;
      grant_q     <= '0;
      load_q      <= 1'b0;
      load_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      load_q      <= load_d;
      load_data_q <= load_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  // Next-state logic: start on grant, count ticks, leave on last tick or abort.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (start_s) begin
          state_d = SHIFT;
          count_d = '0;
          ptr_d   = next_ptr_s;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (abort_s) begin
          state_d = IDLE;
          count_d = '0;
        end else if (last_s) begin
          state_d = IDLE;
          count_d = '0;
        end else if (tick_s) begin
          count_d = count_q + CW'(1);
        end else begin
          count_d = count_q;
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  // Output logic: values presented in the cycle after the decision.
  always_comb begin
    grant_d     = '0;
    load_d      = 1'b0;
    load_data_d = '0;
    if (start_s) begin
      grant_d     = arb_grant_s;
      load_d      = 1'b1;
      load_data_d = sel_data_s;
    end else begin
      grant_d = '0;
    end
    busy_d    = (state_d == SHIFT);
    done_d    = last_s && !abort_s;
    aborted_d = abort_s;
  end

`ifdef SPI_TX_ARB_UNDERRUN_EN
  logic underrun_q, underrun_d;

  // Underrun: master clocks bits while nothing is queued; cleared by deselect.
  always_comb begin
    if (ss_n) begin
      underrun_d = 1'b0;
    end else if ((state_q == IDLE) && bit_tick && (req == '0)) begin
      underrun_d = 1'b1;
    end else begin
      underrun_d = underrun_q;
    end
  end

  // Sticky underrun flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

  assign grant     = grant_q;
  assign load      = load_q;
  assign load_data = load_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule
